// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator with elastic valid/ready pipeline.
// Ports: CLK/Reset, InValid/InReady/Instr in, OutValid/OutReady/BusImm/Fmt/Illegal out, ErrCount.
module imm_gen_pipe #(
  parameter int DATA_WIDTH   = 64,
  parameter int PIPE_DEPTH   = 1,
  parameter int SHIFT_BRANCH = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [31:0]           Instr,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] BusImm,
  output logic [2:0]            Fmt,
  output logic                  Illegal,
  output logic [ERR_CNT_W-1:0]  ErrCount
);

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_B    = 3'd1;
  localparam logic [2:0] F_CB   = 3'd2;
  localparam logic [2:0] F_D    = 3'd3;
  localparam logic [2:0] F_I    = 3'd4;
  localparam logic [2:0] F_IM   = 3'd5;

  logic is_b, is_cb, is_d, is_i, is_im;

  assign is_b  = (Instr[31:26] == 6'b000101)
              || (Instr[31:26] == 6'b100101);
  assign is_cb = (Instr[31:24] == 8'b01010100)
              || (Instr[31:24] == 8'b10110100)
              || (Instr[31:24] == 8'b10110101);
  assign is_d  = (Instr[31:21] == 11'b11111000000)
              || (Instr[31:21] == 11'b11111000010);
  assign is_i  = (Instr[31:22] == 10'b1001000100)
              || (Instr[31:22] == 10'b1011000100)
              || (Instr[31:22] == 10'b1101000100)
              || (Instr[31:22] == 10'b1111000100);
  assign is_im = (Instr[31:23] == 9'b110100101)
              || (Instr[31:23] == 9'b111100101);

  logic [63:0]           wide;
  logic [2:0]            dec_fmt;
  logic                  dec_ill;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [2:0]            in_fmt;
  logic                  in_ill;

  always_comb begin
    wide    = '0;
    dec_fmt = F_NONE;
    dec_ill = 1'b0;
    unique case (1'b1)
      is_b: begin
        wide    = {{38{Instr[25]}}, Instr[25:0]};
        dec_fmt = F_B;
      end
      is_cb: begin
        wide    = {{45{Instr[23]}}, Instr[23:5]};
        dec_fmt = F_CB;
      end
      is_d: begin
        wide    = {{55{Instr[20]}}, Instr[20:12]};
        dec_fmt = F_D;
      end
      is_i: begin
        wide    = {52'b0, Instr[21:10]};
        dec_fmt = F_I;
      end
      is_im: begin
        dec_fmt = F_IM;
        // hw>=2 would shift the whole field out of a 32-bit result
        if (DATA_WIDTH == 32 && Instr[22]) begin
          dec_ill = 1'b1;
        end else begin
          wide = {48'b0, Instr[20:5]} << {Instr[22:21], 4'b0};
        end
      end
      default: dec_ill = 1'b1;
    endcase
    if (SHIFT_BRANCH != 0 && (is_b || is_cb)) begin
      wide = wide << 2;
    end
  end

  // empty slots carry zeros
  assign in_imm = InValid ? wide[DATA_WIDTH-1:0] : '0;
  assign in_fmt = InValid ? dec_fmt : F_NONE;
  assign in_ill = InValid && dec_ill;

  logic                  rdy_b;
  logic                  sv;
  logic [DATA_WIDTH-1:0] simm;
  logic [2:0]            sfmt;
  logic                  sill;

  assign rdy_b = !OutValid || OutReady;

  generate
    if (PIPE_DEPTH == 2) begin : g_two
      logic                  fv;
      logic [DATA_WIDTH-1:0] fimm;
      logic [2:0]            ffmt;
      logic                  fill;

      assign InReady = !fv || rdy_b;

      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
          fv   <= 1'b0;
          fimm <= '0;
          ffmt <= F_NONE;
          fill <= 1'b0;
        end else if (InReady) begin
          fv   <= InValid;
          fimm <= in_imm;
          ffmt <= in_fmt;
          fill <= in_ill;
        end
      end

      assign sv   = fv;
      assign simm = fimm;
      assign sfmt = ffmt;
      assign sill = fill;
    end else begin : g_one
      assign InReady = rdy_b;
      assign sv      = InValid;
      assign simm    = in_imm;
      assign sfmt    = in_fmt;
      assign sill    = in_ill;
    end
  endgenerate

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      OutValid <= 1'b0;
      BusImm   <= '0;
      Fmt      <= F_NONE;
      Illegal  <= 1'b0;
    end else if (rdy_b) begin
      OutValid <= sv;
      BusImm   <= simm;
      Fmt      <= sfmt;
      Illegal  <= sill;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ErrCount <= '0;
    end else if (InValid && InReady && dec_ill && !(&ErrCount)) begin
      ErrCount <= ErrCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised bench for imm_gen_pipe: three configurations against a reference model.
// Instances: 0 = 64b/depth2, 1 = 64b/depth1/shifted branches, 2 = 32b/depth1.
module tb_imm_gen_pipe;

  logic        CLK;
  logic        Reset;
  logic        InValid;
  logic [31:0] Instr;
  logic [2:0]  ordy;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // reference: {illegal, fmt, imm} from the format table with plain arithmetic
  function automatic logic [67:0] model(input logic [31:0] w,
                                        input int dw, input int sb);
    logic [63:0] v;
    logic [2:0]  f;
    logic        il;
    int          hw;
    v  = 0;
    f  = 0;
    il = 0;
    if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
      f = 1;
      v = 64'(w[25:0]);
      if (w[25]) v = v - (64'd1 << 26);
    end else if (w[31:24] == 8'h54 || w[31:24] == 8'hB4
                 || w[31:24] == 8'hB5) begin
      f = 2;
      v = 64'(w[23:5]);
      if (w[23]) v = v - (64'd1 << 19);
    end else if (w[31:21] == 11'h7C0 || w[31:21] == 11'h7C2) begin
      f = 3;
      v = 64'(w[20:12]);
      if (w[20]) v = v - (64'd1 << 9);
    end else if (w[31:22] == 10'h244 || w[31:22] == 10'h2C4
                 || w[31:22] == 10'h344 || w[31:22] == 10'h3C4) begin
      f = 4;
      v = 64'(w[21:10]);
    end else if (w[31:23] == 9'h1A5 || w[31:23] == 9'h1E5) begin
      f  = 5;
      hw = int'(w[22:21]);
      if (dw == 32 && hw >= 2) il = 1;
      else v = 64'(w[20:5]) * (64'd1 << (16 * hw));
    end else begin
      il = 1;
    end
    if (sb != 0 && (f == 1 || f == 2)) v = v * 4;
    if (dw == 32) v = v % (64'd1 << 32);
    return {il, f, v};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[31:26] = ($urandom % 2 != 0) ? 6'b100101 : 6'b000101;
      1: case ($urandom_range(0, 2))
           0:       r[31:24] = 8'h54;
           1:       r[31:24] = 8'hB4;
           default: r[31:24] = 8'hB5;
         endcase
      2: r[31:21] = ($urandom % 2 != 0) ? 11'h7C2 : 11'h7C0;
      3: r[31:22] = {1'b1, 2'($urandom), 7'b1000100};
      4: r[31:23] = {2'b11, 1'($urandom), 6'b100101};
      5: r = 32'h0;
      default: ;
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int DW = (k == 2) ? 32 : 64;
    localparam int PD = (k == 0) ? 2 : 1;
    localparam int SB = (k == 1) ? 1 : 0;

    logic          irdy;
    logic          ov;
    logic [DW-1:0] imm;
    logic [2:0]    fmt;
    logic          ill;
    logic [7:0]    ec;
    logic [63:0]   imm64;
    logic [67:0]   q[$];
    logic [67:0]   e;
    logic [67:0]   held;
    logic          stall;
    int            ecm;
    int            pend;

    assign imm64 = 64'(imm);

    imm_gen_pipe #(
      .DATA_WIDTH(DW), .PIPE_DEPTH(PD),
      .SHIFT_BRANCH(SB), .ERR_CNT_W(8)
    ) dut (
      .CLK(CLK), .Reset(Reset),
      .InValid(InValid), .InReady(irdy), .Instr(Instr),
      .OutValid(ov), .OutReady(ordy[k]),
      .BusImm(imm), .Fmt(fmt), .Illegal(ill), .ErrCount(ec)
    );

    initial begin
      ecm   = 0;
      pend  = 0;
      stall = 0;
    end

    always @(negedge CLK) begin
      if (Reset) begin
        q.delete();
        ecm   = 0;
        stall = 0;
        pend  = 0;
      end else begin
        chk($sformatf("errcnt%0d", k), 72'(ec), 72'(ecm));
        chk($sformatf("inready%0d", k), 72'(irdy),
            72'(!(q.size() == PD && !ordy[k])));
        if (stall) begin
          chk($sformatf("hold%0d", k), {3'b0, ov, ill, fmt, imm64},
              {3'b0, 1'b1, held});
        end
        if (ov && ordy[k]) begin
          if (q.size() == 0) begin
            chk($sformatf("extra_out%0d", k), 72'(1), 72'(0));
          end else begin
            e = q.pop_front();
            chk($sformatf("out%0d", k), 72'({ill, fmt, imm64}), 72'(e));
          end
        end
        stall = ov && !ordy[k];
        held  = {ill, fmt, imm64};
        if (InValid && irdy) begin
          e = model(Instr, DW, SB);
          q.push_back(e);
          if (e[67] && ecm < 255) ecm++;
        end
        pend = q.size();
      end
    end
  end

  initial CLK = 0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [71:0] r0, r1, r2;

  // one word, full drain; r* = {ov, ill, fmt, imm} at each instance's latency
  task automatic send_dir(input logic [31:0] w);
    @(posedge CLK);
    #1;
    ordy    = 3'b111;
    InValid = 1;
    Instr   = w;
    @(posedge CLK);
    #1;
    InValid = 0;
    @(negedge CLK);
    chk("lat_early0", 72'(g[0].ov), 72'(0));
    r1 = 72'({g[1].ov, g[1].ill, g[1].fmt, g[1].imm64});
    r2 = 72'({g[2].ov, g[2].ill, g[2].fmt, g[2].imm64});
    @(negedge CLK);
    r0 = 72'({g[0].ov, g[0].ill, g[0].fmt, g[0].imm64});
  endtask

  function automatic logic [71:0] ex(input logic il, input logic [2:0] f,
                                     input logic [63:0] v);
    return 72'({1'b1, il, f, v});
  endfunction

  int n;
  bit acc;

  initial begin
    Reset   = 1;
    InValid = 0;
    Instr   = 0;
    ordy    = 3'b111;
    #12;
    chk("rst_ov0",  72'(g[0].ov),    72'(0));
    chk("rst_imm0", 72'(g[0].imm64), 72'(0));
    chk("rst_fmt1", 72'(g[1].fmt),   72'(0));
    chk("rst_ill2", 72'(g[2].ill),   72'(0));
    chk("rst_ec0",  72'(g[0].ec),    72'(0));
    chk("rst_rdy0", 72'(g[0].irdy),  72'(1));
    @(posedge CLK);
    #2;
    Reset = 0;

    send_dir(32'h17FFFFFF);
    chk("b_all1", r0, ex(0, 1, 64'hFFFF_FFFF_FFFF_FFFF));
    send_dir(32'hB4800000);
    chk("cbz_sh", r1, ex(0, 2, 64'hFFFF_FFFF_FFF0_0000));
    send_dir(32'hF85FF000);
    chk("ldur64", r0, ex(0, 3, 64'hFFFF_FFFF_FFFF_FFFF));
    chk("ldur32", r2, ex(0, 3, 64'h0000_0000_FFFF_FFFF));
    send_dir(32'h913FFC00);
    chk("addi", r0, ex(0, 4, 64'h0FFF));
    send_dir(32'hD2F7DDE0);
    chk("movz64", r0, ex(0, 5, 64'hBEEF_0000_0000_0000));
    chk("movz32", r2, ex(1, 5, 64'h0));
    send_dir(32'h0);
    chk("illeg", r0, ex(1, 0, 64'h0));

    // 8 words through depth-2 with OutReady 1,0,0 repeating
    n = 0;
    @(posedge CLK);
    #1;
    InValid = 1;
    Instr   = rand_instr();
    for (int c = 0; c < 100 && n < 8; c++) begin
      ordy = (c % 3 == 0) ? 3'b111 : 3'b000;
      @(negedge CLK);
      acc = g[0].irdy;
      if (acc) n++;
      @(posedge CLK);
      #1;
      if (acc) Instr = rand_instr();
    end
    InValid = 0;
    chk("stream8", 72'(n), 72'(8));

    for (int c = 0; c < 400; c++) begin
      InValid = ($urandom % 4) != 0;
      Instr   = rand_instr();
      ordy    = 3'($urandom);
      @(posedge CLK);
      #1;
    end
    InValid = 0;
    ordy    = 3'b111;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      int p;
      p = (k == 0) ? g[0].pend : (k == 1) ? g[1].pend : g[2].pend;
      chk($sformatf("drain%0d", k), 72'(p), 72'(0));
    end

    // reset with two entries in flight
    send_dir(32'h0);
    @(posedge CLK);
    #1;
    ordy    = 3'b000;
    InValid = 1;
    Instr   = 32'h0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    InValid = 0;
    #2;
    chk("pre_rst_ov0", 72'(g[0].ov), 72'(1));
    Reset = 1;
    #1;
    chk("arst_ov0", 72'(g[0].ov), 72'(0));
    chk("arst_ov1", 72'(g[1].ov), 72'(0));
    chk("arst_ec0", 72'(g[0].ec), 72'(0));
    chk("arst_ec2", 72'(g[2].ec), 72'(0));
    @(negedge CLK);
    @(posedge CLK);
    #2;
    Reset = 0;
    ordy  = 3'b111;
    #1;
    chk("post_rdy0", 72'(g[0].irdy), 72'(1));
    send_dir(32'h913FFC00);
    chk("post_lat0", r0, ex(0, 4, 64'h0FFF));
    chk("post_lat1", r1, ex(0, 4, 64'h0FFF));

    // 300 illegal words saturate the counter
    @(posedge CLK);
    #1;
    ordy    = 3'b111;
    InValid = 1;
    Instr   = 32'h0;
    repeat (300) @(posedge CLK);
    #1;
    InValid = 0;
    @(negedge CLK);
    chk("sat0", 72'(g[0].ec), 72'(255));
    chk("sat1", 72'(g[1].ec), 72'(255));
    chk("sat2", 72'(g[2].ec), 72'(255));
    repeat (4) @(posedge CLK);
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
